// File: rtl/alu_btn_sequencer.sv
// Board-level ALU sequencer: synchronised, edge-detected buttons load A/B/OP from the
// switches (or feed the result back into A), and a registered result with flags follows each load.
module alu_btn_sequencer #(
    parameter int NB_DATA  = 8,
    parameter int NB_OP    = 6,
    parameter int NB_FLAGS = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [3:0]          i_buttons,
    input  logic [NB_DATA-1:0]  i_switches,
    output logic [NB_DATA-1:0]  o_leds,
    output logic [NB_FLAGS-1:0] o_flags,
    output logic                o_op_err,
    output logic                o_result_valid
);

    localparam int MSB = NB_DATA - 1;

    localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'd32);
    localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'd34);
    localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'd36);
    localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'd37);
    localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'd38);
    localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'd39);
    localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'd3);
    localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'd2);

    logic [3:0]          btn_meta_r;
    logic [3:0]          btn_sync_r;
    logic [3:0]          btn_prev_r;
    logic [3:0]          btn_armed_r;
    logic [1:0]          fill_r;
    logic [NB_DATA-1:0]  sw_meta_r;
    logic [NB_DATA-1:0]  sw_sync_r;
    logic [3:0]          pulse_s;

    logic [NB_DATA-1:0]  a_r;
    logic [NB_DATA-1:0]  b_r;
    logic [NB_OP-1:0]    op_r;
    logic                load_seen_r;

    logic [NB_DATA:0]    sum_s;
    logic [NB_DATA-1:0]  diff_s;
    logic [NB_DATA-1:0]  res_s;
    logic                carry_s;
    logic                ovf_s;
    logic                err_s;
    logic [NB_FLAGS-1:0] flags_s;

    logic [NB_DATA-1:0]  leds_r;
    logic [NB_FLAGS-1:0] flags_r;
    logic                op_err_r;
    logic                valid_r;

    // A button only fires once it has been genuinely sampled low after reset, so a
    // button held through reset cannot masquerade as a fresh press.
    assign pulse_s = btn_sync_r & ~btn_prev_r & btn_armed_r;

    // Input synchronisers, edge history and post-reset arming
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_meta_r  <= 4'b0000;
            btn_sync_r  <= 4'b0000;
            btn_prev_r  <= 4'b0000;
            btn_armed_r <= 4'b0000;
            fill_r      <= 2'b00;
            sw_meta_r   <= '0;
            sw_sync_r   <= '0;
        end else begin
            btn_meta_r  <= i_buttons;
            btn_sync_r  <= btn_meta_r;
            btn_prev_r  <= btn_sync_r;
            fill_r      <= {fill_r[0], 1'b1};
            btn_armed_r <= btn_armed_r | ({4{fill_r[1]}} & ~btn_sync_r);
            sw_meta_r   <= i_switches;
            sw_sync_r   <= sw_meta_r;
        end
    end

    // Operand and opcode registers, loaded by button pulses
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            a_r         <= '0;
            b_r         <= '0;
            op_r        <= OP_ADD;
            load_seen_r <= 1'b0;
        end else begin
            if (pulse_s[0]) begin
                a_r <= sw_sync_r;
            end else if (pulse_s[3]) begin
                a_r <= leds_r;
            end
            if (pulse_s[1]) begin
                b_r <= sw_sync_r;
            end
            if (pulse_s[2]) begin
                op_r <= sw_sync_r[NB_OP-1:0];
            end
            load_seen_r <= |pulse_s;
        end
    end

    // ALU datapath and status flags
    always_comb begin
        sum_s   = {1'b0, a_r} + {1'b0, b_r};
        diff_s  = a_r - b_r;
        res_s   = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        case (op_r)
            OP_ADD: begin
                res_s   = sum_s[NB_DATA-1:0];
                carry_s = sum_s[NB_DATA];
                ovf_s   = (a_r[MSB] == b_r[MSB]) && (sum_s[MSB] != a_r[MSB]);
            end
            OP_SUB: begin
                res_s   = diff_s;
                carry_s = (a_r < b_r);
                ovf_s   = (a_r[MSB] != b_r[MSB]) && (diff_s[MSB] != a_r[MSB]);
            end
            OP_AND:  res_s = a_r & b_r;
            OP_OR:   res_s = a_r | b_r;
            OP_XOR:  res_s = a_r ^ b_r;
            OP_NOR:  res_s = ~(a_r | b_r);
            OP_SRA:  res_s = $unsigned($signed(a_r) >>> b_r);
            OP_SRL:  res_s = a_r >> b_r;
            default: begin
                res_s = '0;
                err_s = 1'b1;
            end
        endcase
        flags_s    = '0;
        flags_s[3] = res_s[MSB];
        flags_s[2] = (res_s == '0);
        flags_s[1] = carry_s;
        flags_s[0] = ovf_s;
    end

    // Result registers refresh only in the cycle after a load
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            leds_r   <= '0;
            flags_r  <= '0;
            op_err_r <= 1'b0;
            valid_r  <= 1'b0;
        end else if (load_seen_r) begin
            leds_r   <= res_s;
            flags_r  <= flags_s;
            op_err_r <= err_s;
            valid_r  <= 1'b1;
        end else begin
            valid_r  <= 1'b0;
        end
    end

    assign o_leds         = leds_r;
    assign o_flags        = flags_r;
    assign o_op_err       = op_err_r;
    assign o_result_valid = valid_r;

endmodule

// File: tb/tb_alu_btn_sequencer.sv
// Directed bench for alu_btn_sequencer: an arithmetic model predicts each result and the
// edge on which it appears; a per-cycle compare process checks every output.
module tb_alu_btn_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] buttons;
    logic [7:0] switches;
    logic [7:0] leds;
    logic [3:0] flags;
    logic       op_err;
    logic       result_valid;

    alu_btn_sequencer #(.NB_DATA(8), .NB_OP(6), .NB_FLAGS(4)) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_buttons      (buttons),
        .i_switches     (switches),
        .o_leds         (leds),
        .o_flags        (flags),
        .o_op_err       (op_err),
        .o_result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // architectural model state
    int m_a, m_b, m_op, m_res;
    // currently expected visible outputs, plus updates scheduled by rising-edge index
    logic [7:0] e_leds;
    logic [3:0] e_flags;
    logic       e_err;
    logic       e_valid;
    logic [7:0] q_leds[int];
    logic [3:0] q_flags[int];
    logic       q_err[int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void alu_ref(input int a, input int b, input int op,
                                    output int res, output logic [3:0] fl, output logic err);
        int sa, sb, full;
        logic c, v;
        c = 1'b0; v = 1'b0; err = 1'b0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            32: begin
                full = a + b;
                res = full % 256;
                c = (full > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            34: begin
                res = (a - b + 256) % 256;
                c = (a < b);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            36: res = a & b;
            37: res = a | b;
            38: res = a ^ b;
            39: res = (~(a | b)) & 255;
            3:  res = (b >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> b) & 255);
            2:  res = (b >= 8) ? 0 : (a >> b);
            default: begin
                res = 0;
                err = 1'b1;
            end
        endcase
        fl = {(res >= 128), (res == 0), c, v};
    endfunction

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (q_leds.exists(cyc)) begin
            e_leds  = q_leds[cyc];
            e_flags = q_flags[cyc];
            e_err   = q_err[cyc];
            e_valid = 1'b1;
            q_leds.delete(cyc);
            q_flags.delete(cyc);
            q_err.delete(cyc);
        end else begin
            e_valid = 1'b0;
        end
        check("valid", result_valid, e_valid);
        check("leds", leds, e_leds);
        check("flags", flags, e_flags);
        check("op_err", op_err, e_err);
    end

    // press the masked buttons with a switch value, hold, release and let it settle
    task automatic press(input logic [3:0] mask, input logic [7:0] sw, input int hold);
        int r;
        logic [3:0] fl;
        logic er;
        @(negedge clk);
        switches = sw;
        buttons  = buttons | mask;
        if (mask[0]) m_a = sw;
        else if (mask[3]) m_a = m_res;
        if (mask[1]) m_b = sw;
        if (mask[2]) m_op = sw & 63;
        alu_ref(m_a, m_b, m_op, r, fl, er);
        m_res = r;
        // first sampling edge is cyc+1, so the result lands on edge cyc+4
        q_leds[cyc + 4]  = 8'(r);
        q_flags[cyc + 4] = fl;
        q_err[cyc + 4]   = er;
        repeat (hold) @(negedge clk);
        buttons = buttons & ~mask;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 32; m_res = 0;
        e_leds = 8'h00; e_flags = 4'h0; e_err = 1'b0;
        q_leds.delete(); q_flags.delete(); q_err.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        buttons = 4'b0000;
        switches = 8'h00;
        e_valid = 1'b0;
        model_reset();
        #12;
        check("rst_leds", leds, 8'h00);
        check("rst_flags", flags, 4'h0);
        check("rst_valid", result_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ADD with signed overflow
        press(4'b0001, 8'h7F, 3);
        press(4'b0010, 8'h01, 3);
        press(4'b0100, 8'd32, 3);
        check("add_leds", leds, 8'h80);
        check("add_flags", flags, 4'b1001);

        // SUB: zero, then borrow
        press(4'b0001, 8'h05, 3);
        press(4'b0010, 8'h05, 3);
        press(4'b0100, 8'd34, 3);
        check("sub_zero", {flags, leds}, {4'b0100, 8'h00});
        press(4'b0010, 8'h06, 3);
        check("sub_borrow", {flags, leds}, {4'b1010, 8'hFF});
        press(4'b0010, 8'h06, 5);

        // shifts
        press(4'b0001, 8'h90, 3);
        press(4'b0100, 8'd3, 3);
        press(4'b0010, 8'd2, 3);
        check("sra_2", leds, 8'hE4);
        press(4'b0010, 8'd9, 3);
        check("sra_9", leds, 8'hFF);
        press(4'b0100, 8'd2, 3);
        press(4'b0010, 8'd2, 3);
        check("srl_2", leds, 8'h24);
        press(4'b0010, 8'd8, 3);
        check("srl_8", leds, 8'h00);

        // accumulate presses, then a long hold counts once
        press(4'b0001, 8'd1, 3);
        press(4'b0010, 8'd1, 3);
        press(4'b0100, 8'd32, 3);
        check("acc_base", leds, 8'd2);
        press(4'b1000, 8'h00, 3);
        check("acc_1", leds, 8'd3);
        press(4'b1000, 8'h00, 3);
        check("acc_2", leds, 8'd4);
        press(4'b1000, 8'h00, 3);
        press(4'b1000, 8'h00, 20);
        check("acc_hold", leds, 8'd6);

        // invalid opcode and recovery
        press(4'b0100, 8'h3F, 3);
        check("bad_op", {op_err, flags, leds}, {1'b1, 4'b0100, 8'h00});
        press(4'b0001, 8'hF0, 3);
        press(4'b0010, 8'h3C, 3);
        press(4'b0100, 8'd36, 3);
        check("and_ok", {op_err, leds}, {1'b0, 8'h30});

        // simultaneous loads
        press(4'b1110, 8'h25, 3);
        check("acc_b_op", leds, 8'h35);
        press(4'b1001, 8'h42, 3);
        check("a_over_acc", leds, 8'h67);

        // reset between edges 2 and 3 of a load-A press, button held through it
        @(negedge clk);
        switches = 8'h55;
        buttons[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_out", {result_valid, op_err, flags, leds}, 14'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        buttons[0] = 1'b0;
        repeat (4) @(negedge clk);
        press(4'b0010, 8'h01, 3);
        check("post_rst_a0", leds, 8'h01);
        press(4'b0001, 8'h03, 3);
        check("post_rst_a3", leds, 8'h04);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
